motion_counter: RTL and testbench
=================================

Name: motion_counter

Overview:
- Parametrised successor to the tick divider and coordinate counter pair.
- Merges them into one axis-motion engine: a programmable tick divider drives a position register, updated by a signed velocity.
- Velocity is itself integrated from a signed acceleration, e.g. gravity for falling sprites, and saturated at a terminal speed.
- Position is confined to [pos_min, pos_max] by clamp or wrap, with edge-hit pulses for collision/game logic.
- One instance per axis per sprite; sits between the game FSM and the draw datapath.

Parameters:
- POS_W, 8: position width, unsigned.
- VEL_W, 4: velocity/acceleration width, two's-complement signed.
- DIV_W, 26: tick divider width.
- WRAP, 0: 0 = clamp at bounds, 1 = wrap within bounds.

Ports:
- clk, in, 1: clock.
- resetn, in, 1: reset; asynchronous, active-low.
- enable, in, 1: count/update enable.
- load, in, 1: synchronous load of position and velocity.
- load_pos, in, POS_W: position loaded on load.
- load_vel, in, VEL_W: signed velocity loaded on load.
- period, in, DIV_W: update every period+1 enabled cycles.
- accel, in, VEL_W: signed velocity increment per update.
- vmax, in, VEL_W-1: terminal speed magnitude.
- pos_min, in, POS_W: lower bound, inclusive.
- pos_max, in, POS_W: upper bound, inclusive.
- pos, out, POS_W: current position.
- vel, out, VEL_W: current signed velocity.
- tick, out, 1: one-cycle pulse on the edge pos/vel update.
- hit_min, out, 1: one-cycle pulse, lower bound crossed on this update.
- hit_max, out, 1: one-cycle pulse, upper bound crossed on this update.

Behaviour:
- Reset (async assert, sync release): div_cnt=0, pos=0, vel=0, tick=0, hit_min=0, hit_max=0.
- All outputs are registered. tick/hit_* default to 0 every cycle.
- Priority: load > enable > hold.
- load=1: pos<=load_pos, vel<=load_vel, div_cnt<=0, no tick. Values are visible next cycle. load_pos/load_vel are not range-checked.
- enable=0 and load=0: div_cnt, pos, vel held; no pulses.
- Divider (enable=1):
  - div_cnt>=period: div_cnt<=0 and an update fires.
  - Otherwise div_cnt+1.
  - period=0 gives an update every enabled cycle.
  - Lowering period below div_cnt fires on the next enabled cycle, with no long wrap.
- Update, computed in POS_W+2 bit signed arithmetic:
  - npos = pos + vel, using the velocity before this update's acceleration.
  - nvel = vel + accel, saturated to [-vmax, +vmax].
  - vmax=0 forces vel to 0.
  - tick=1.
- Bounds, when pos_min<=pos_max:
  - npos>pos_max: hit_max=1.
    - WRAP=0: pos<=pos_max, vel<=0.
    - WRAP=1: pos<=pos_min+(npos-pos_max-1), vel<=nvel.
  - npos<pos_min: hit_min=1.
    - WRAP=0: pos<=pos_min, vel<=0.
    - WRAP=1: pos<=pos_max-(pos_min-npos-1), vel<=nvel.
  - Otherwise pos<=npos, vel<=nvel.
  - WRAP=1 result is defined only if |vel| <= pos_max-pos_min+1. A bench must not exceed this.
  - Landing exactly on a bound is not a hit.
- pos_min>pos_max: bounds disabled; pos<=npos mod 2^POS_W; no hit pulses.
- Bound/vmax/accel/period changes take effect at the next update; no restart.
- Reset mid-count: immediate return to reset values; any pending update is lost.

Optional Feature:
- MOTION_COUNTER_BOUNCE_EN.
- Defined and WRAP=0: on a bound hit, pos clamps, and vel<=-nvel saturated to [-vmax, +vmax] (elastic bounce).
- Undefined: vel<=0 on a clamp hit.
- No effect when WRAP=1.

Test Plan:
- Divider:
  - Stimulus: period=3, enable=1, load pos=10 vel=+2 accel=0 vmax=7, bounds 0..159.
  - Required: tick every 4th cycle; pos 12, 14, 16.
  - Stimulus: drop enable for 5 cycles.
  - Required: pos and div_cnt frozen, no tick.
- Gravity saturation:
  - Stimulus: period=0, load vel=0, accel=+1, vmax=3.
  - Required: vel 1, 2, 3, 3, 3; pos deltas 0, 1, 2, 3, 3.
- Clamp:
  - Stimulus: pos=157, vel=+3, bounds 0..159, WRAP=0.
  - Required: pos=159, vel=0, hit_max one cycle.
  - With MOTION_COUNTER_BOUNCE_EN: vel=-3.
- Wrap:
  - Stimulus: WRAP=1, bounds 10..19, pos=18, vel=+3.
  - Required: pos=11, hit_max=1.
  - Stimulus: pos=11, vel=-3.
  - Required: pos=18, hit_min=1.
- Load priority / exact bound:
  - Stimulus: load and update in the same cycle.
  - Required: load values win, no tick.
  - Stimulus: landing exactly on pos_max.
  - Required: no hit.
- Async reset:
  - Stimulus: assert resetn=0 mid-period, between clock edges.
  - Required: outputs zero immediately.
  - After release: first tick period+1 cycles later.

Source files
------------

// File: rtl/motion_counter.sv
`default_nettype none
// ============================================================================
// Module      : motion_counter
// Description : Single-axis motion engine. A programmable tick divider paces
//               updates of a position register. Each update adds the current
//               signed velocity to the position. It then integrates a signed
//               acceleration into the velocity, saturating the velocity at a
//               terminal speed. The position is confined to [pos_min, pos_max]
//               either by clamping (WRAP=0) or by wrapping (WRAP=1).
//               One-cycle hit pulses flag bound crossings.
//
// Ports       : clk       - clock
//               resetn    - asynchronous active-low reset
//               enable    - count/update enable
//               load      - synchronous load of pos/vel (beats enable)
//               load_pos  - position loaded on load
//               load_vel  - signed velocity loaded on load
//               period    - update every period+1 enabled cycles
//               accel     - signed velocity increment per update
//               vmax      - terminal speed magnitude
//               pos_min   - lower bound, inclusive
//               pos_max   - upper bound, inclusive (min>max disables bounds)
//               pos       - current position
//               vel       - current signed velocity
//               tick      - one-cycle pulse with each pos/vel update
//               hit_min   - one-cycle pulse, lower bound crossed
//               hit_max   - one-cycle pulse, upper bound crossed
//
// Options     : MOTION_COUNTER_BOUNCE_EN - with WRAP=0, a bound hit reflects
//               the velocity (vel <= -nvel) instead of zeroing it.
//
// Revision    : 1.0 - initial release
// ============================================================================
module motion_counter #(
    parameter int POS_W = 8,
    parameter int VEL_W = 4,
    parameter int DIV_W = 26,
    parameter int WRAP  = 0
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             enable,
    input  logic             load,
    input  logic [POS_W-1:0] load_pos,
    input  logic [VEL_W-1:0] load_vel,
    input  logic [DIV_W-1:0] period,
    input  logic [VEL_W-1:0] accel,
    input  logic [VEL_W-2:0] vmax,
    input  logic [POS_W-1:0] pos_min,
    input  logic [POS_W-1:0] pos_max,
    output logic [POS_W-1:0] pos,
    output logic [VEL_W-1:0] vel,
    output logic             tick,
    output logic             hit_min,
    output logic             hit_max
);

    // Position math is done two bits wider than the position so that
    // overshoot past either end is representable as a signed value.
    localparam int c_EXT_W = POS_W + 2;
    localparam int c_VS_W  = VEL_W + 1;

    logic [DIV_W-1:0]          r_div_cnt;
    logic [POS_W-1:0]          r_pos;
    logic signed [VEL_W-1:0]   r_vel;
    logic                      r_tick;
    logic                      r_hit_min;
    logic                      r_hit_max;

    logic                      w_fire;
    logic signed [c_EXT_W-1:0] w_pos_x;
    logic signed [c_EXT_W-1:0] w_vel_x;
    logic signed [c_EXT_W-1:0] w_min_x;
    logic signed [c_EXT_W-1:0] w_max_x;
    logic signed [c_EXT_W-1:0] w_npos;
    logic signed [c_VS_W-1:0]  w_vsum;
    logic signed [c_VS_W-1:0]  w_vmax_x;
    logic signed [VEL_W-1:0]   w_nvel;
    logic signed [VEL_W-1:0]   w_hit_vel;
    logic                      w_bounds_en;
    logic                      w_over;
    logic                      w_under;
    logic [POS_W-1:0]          w_wrap_hi;
    logic [POS_W-1:0]          w_wrap_lo;
    logic [POS_W-1:0]          w_next_pos;
    logic signed [VEL_W-1:0]   w_next_vel;

    // ">=" rather than "==" so that lowering period below the running count
    // fires on the next enabled cycle instead of wrapping the whole counter.
    assign w_fire = (r_div_cnt >= period);

    assign w_pos_x  = {2'b00, r_pos};
    assign w_vel_x  = {{(c_EXT_W-VEL_W){r_vel[VEL_W-1]}}, r_vel};
    assign w_min_x  = {2'b00, pos_min};
    assign w_max_x  = {2'b00, pos_max};
    assign w_npos   = w_pos_x + w_vel_x;

    // Velocity sum carries one guard bit so saturation sees the true sum.
    assign w_vsum   = {r_vel[VEL_W-1], r_vel} + {accel[VEL_W-1], accel};
    assign w_vmax_x = {2'b00, vmax};

    always_comb begin
        w_nvel = w_vsum[VEL_W-1:0];
        if (w_vsum > w_vmax_x) begin
            w_nvel = VEL_W'(w_vmax_x);
        end else if (w_vsum < -w_vmax_x) begin
            w_nvel = VEL_W'(-w_vmax_x);
        end
    end

    // nvel is already within [-vmax, +vmax], so its negation is too.
`ifdef MOTION_COUNTER_BOUNCE_EN
    assign w_hit_vel = -w_nvel;
`else
    assign w_hit_vel = '0;
`endif

    assign w_bounds_en = (pos_min <= pos_max);
    assign w_over      = w_bounds_en && (w_npos > w_max_x);
    assign w_under     = w_bounds_en && (w_npos < w_min_x);

    // Wrap targets only need the low POS_W bits; the arithmetic is
    // identical modulo 2^POS_W.
    assign w_wrap_hi = pos_min + (w_npos[POS_W-1:0] - pos_max - POS_W'(1));
    assign w_wrap_lo = pos_max - (pos_min - w_npos[POS_W-1:0] - POS_W'(1));

    always_comb begin
        w_next_pos = w_npos[POS_W-1:0];
        w_next_vel = w_nvel;
        if (w_over) begin
            if (WRAP != 0) begin
                w_next_pos = w_wrap_hi;
            end else begin
                w_next_pos = pos_max;
                w_next_vel = w_hit_vel;
            end
        end else if (w_under) begin
            if (WRAP != 0) begin
                w_next_pos = w_wrap_lo;
            end else begin
                w_next_pos = pos_min;
                w_next_vel = w_hit_vel;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_div_cnt <= '0;
            r_pos     <= '0;
            r_vel     <= '0;
            r_tick    <= 1'b0;
            r_hit_min <= 1'b0;
            r_hit_max <= 1'b0;
        end else begin
            r_tick    <= 1'b0;
            r_hit_min <= 1'b0;
            r_hit_max <= 1'b0;
            if (load) begin
                r_pos     <= load_pos;
                r_vel     <= load_vel;
                r_div_cnt <= '0;
            end else if (enable) begin
                if (w_fire) begin
                    r_div_cnt <= '0;
                    r_pos     <= w_next_pos;
                    r_vel     <= w_next_vel;
                    r_tick    <= 1'b1;
                    r_hit_min <= w_under;
                    r_hit_max <= w_over;
                end else begin
                    r_div_cnt <= r_div_cnt + DIV_W'(1);
                end
            end
        end
    end

    assign pos     = r_pos;
    assign vel     = r_vel;
    assign tick    = r_tick;
    assign hit_min = r_hit_min;
    assign hit_max = r_hit_max;

endmodule
`default_nettype wire

// File: tb/tb_motion_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_motion_counter
// Description : Self-checking bench for motion_counter. Drives a clamp
//               (WRAP=0) and a wrap (WRAP=1) instance with identical stimulus
//               and compares both against an integer reference model every
//               cycle, plus directed checks of the key scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_motion_counter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn, enable, load;
    logic [7:0]  load_pos, pos_min, pos_max;
    logic [3:0]  load_vel, accel;
    logic [2:0]  vmax;
    logic [25:0] period;

    logic [7:0]  pos_c, pos_w;
    logic [3:0]  vel_c, vel_w;
    logic        tick_c, tick_w, hmin_c, hmin_w, hmax_c, hmax_w;

    motion_counter #(.POS_W(8), .VEL_W(4), .DIV_W(26), .WRAP(0)) u_clamp (
        .clk(clk), .resetn(resetn), .enable(enable), .load(load),
        .load_pos(load_pos), .load_vel(load_vel), .period(period),
        .accel(accel), .vmax(vmax), .pos_min(pos_min), .pos_max(pos_max),
        .pos(pos_c), .vel(vel_c), .tick(tick_c),
        .hit_min(hmin_c), .hit_max(hmax_c)
    );

    motion_counter #(.POS_W(8), .VEL_W(4), .DIV_W(26), .WRAP(1)) u_wrap (
        .clk(clk), .resetn(resetn), .enable(enable), .load(load),
        .load_pos(load_pos), .load_vel(load_vel), .period(period),
        .accel(accel), .vmax(vmax), .pos_min(pos_min), .pos_max(pos_max),
        .pos(pos_w), .vel(vel_w), .tick(tick_w),
        .hit_min(hmin_w), .hit_max(hmax_w)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: index 0 = clamp instance, 1 = wrap instance.
    int m_pos[2], m_vel[2], m_tick[2], m_hmin[2], m_hmax[2];
    int m_div;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_pos[d] = 0; m_vel[d] = 0; m_tick[d] = 0;
            m_hmin[d] = 0; m_hmax[d] = 0;
        end
        m_div = 0;
    endtask

    function automatic int hit_vel(input int nvel);
`ifdef MOTION_COUNTER_BOUNCE_EN
        return -nvel;
`else
        return 0;
`endif
    endfunction

    task automatic model_update(input int d);
        int npos, nvel, vm, pmin, pmax;
        vm   = int'(vmax);
        pmin = int'(pos_min);
        pmax = int'(pos_max);
        npos = m_pos[d] + m_vel[d];
        nvel = m_vel[d] + int'($signed(accel));
        if (nvel > vm)  nvel = vm;
        if (nvel < -vm) nvel = -vm;
        m_tick[d] = 1;
        if (pmin > pmax) begin
            m_pos[d] = npos & 255;
            m_vel[d] = nvel;
        end else if (npos > pmax) begin
            m_hmax[d] = 1;
            if (d == 1) begin
                m_pos[d] = (pmin + (npos - pmax - 1)) & 255;
                m_vel[d] = nvel;
            end else begin
                m_pos[d] = pmax;
                m_vel[d] = hit_vel(nvel);
            end
        end else if (npos < pmin) begin
            m_hmin[d] = 1;
            if (d == 1) begin
                m_pos[d] = (pmax - (pmin - npos - 1)) & 255;
                m_vel[d] = nvel;
            end else begin
                m_pos[d] = pmin;
                m_vel[d] = hit_vel(nvel);
            end
        end else begin
            m_pos[d] = npos;
            m_vel[d] = nvel;
        end
    endtask

    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            m_tick[d] = 0; m_hmin[d] = 0; m_hmax[d] = 0;
        end
        if (load) begin
            for (int d = 0; d < 2; d++) begin
                m_pos[d] = int'(load_pos);
                m_vel[d] = int'($signed(load_vel));
            end
            m_div = 0;
        end else if (enable) begin
            if (m_div >= int'(period)) begin
                m_div = 0;
                model_update(0);
                model_update(1);
            end else begin
                m_div++;
            end
        end
    endtask

    task automatic compare_all();
        check("pos_clamp",  pos_c,            m_pos[0]);
        check("vel_clamp",  $signed(vel_c),   m_vel[0]);
        check("tick_clamp", tick_c,           m_tick[0]);
        check("hmin_clamp", hmin_c,           m_hmin[0]);
        check("hmax_clamp", hmax_c,           m_hmax[0]);
        check("pos_wrap",   pos_w,            m_pos[1]);
        check("vel_wrap",   $signed(vel_w),   m_vel[1]);
        check("tick_wrap",  tick_w,           m_tick[1]);
        check("hmin_wrap",  hmin_w,           m_hmin[1]);
        check("hmax_wrap",  hmax_w,           m_hmax[1]);
    endtask

    // One clock: advance the model from the inputs in force, then sample
    // the DUTs 1 time unit after the edge.
    task automatic step();
        if (resetn) model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    int ep[5] = '{50, 51, 53, 56, 59};
    int ev[5] = '{1, 2, 3, 3, 3};
    int bounce_v;
    int pmin_r, pmax_r;

    initial begin
`ifdef MOTION_COUNTER_BOUNCE_EN
        bounce_v = -3;
`else
        bounce_v = 0;
`endif
        resetn = 1'b0; enable = 1'b0; load = 1'b0;
        load_pos = '0; load_vel = '0; period = '0; accel = '0; vmax = '0;
        pos_min = '0; pos_max = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();

        // Divider: period 3, vel +2
        pos_min = 8'd0; pos_max = 8'd159; vmax = 3'd7; accel = 4'd0;
        period = 26'd3; resetn = 1'b1; enable = 1'b1;
        load = 1'b1; load_pos = 8'd10; load_vel = 4'd2;
        step();
        check("load_no_tick", tick_c, 0);
        load = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            repeat (3) step();
            check("div_quiet", tick_c, 0);
            step();
            check("div_tick", tick_c, 1);
            check("div_pos", pos_c, 10 + 2 * k);
        end
        // Freeze mid-count
        repeat (2) step();
        enable = 1'b0;
        repeat (5) begin
            step();
            check("freeze_tick", tick_c, 0);
        end
        check("freeze_pos", pos_c, 16);
        enable = 1'b1;
        step();
        check("resume_quiet", tick_c, 0);
        step();
        check("resume_tick", tick_c, 1);
        check("resume_pos", pos_c, 18);

        // Gravity saturation
        period = 26'd0; accel = 4'd1; vmax = 3'd3;
        load = 1'b1; load_pos = 8'd50; load_vel = 4'd0;
        step();
        load = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("grav_vel", $signed(vel_c), ev[i]);
            check("grav_pos", pos_c, ep[i]);
        end

        // Clamp at upper bound
        accel = 4'd0; vmax = 3'd7;
        load = 1'b1; load_pos = 8'd157; load_vel = 4'd3;
        step();
        load = 1'b0;
        step();
        check("clamp_pos", pos_c, 159);
        check("clamp_vel", $signed(vel_c), bounce_v);
        check("clamp_hit", hmax_c, 1);
        step();
        check("clamp_hit_pulse", hmax_c, 0);

        // Landing exactly on the bound
        load = 1'b1; load_pos = 8'd156; load_vel = 4'd3;
        step();
        load = 1'b0;
        step();
        check("exact_pos", pos_c, 159);
        check("exact_nohit", hmax_c, 0);

        // Load beats a due update
        load = 1'b1; load_pos = 8'd77; load_vel = 4'hE;
        step();
        check("prio_pos", pos_c, 77);
        check("prio_vel", $signed(vel_c), -2);
        check("prio_tick", tick_c, 0);
        load = 1'b0;

        // Wrap within 10..19
        pos_min = 8'd10; pos_max = 8'd19;
        load = 1'b1; load_pos = 8'd18; load_vel = 4'd3;
        step();
        load = 1'b0;
        step();
        check("wrap_hi_pos", pos_w, 11);
        check("wrap_hi_hit", hmax_w, 1);
        load = 1'b1; load_pos = 8'd11; load_vel = 4'hD;
        step();
        load = 1'b0;
        step();
        check("wrap_lo_pos", pos_w, 18);
        check("wrap_lo_hit", hmin_w, 1);

        // Async reset mid-period
        pos_min = 8'd0; pos_max = 8'd159; period = 26'd3;
        load = 1'b1; load_pos = 8'd20; load_vel = 4'd1;
        step();
        load = 1'b0;
        repeat (2) step();
        #2;
        resetn = 1'b0;
        #1;
        model_reset();
        check("arst_pos", pos_c, 0);
        check("arst_vel", vel_c, 0);
        check("arst_pos_w", pos_w, 0);
        step();
        resetn = 1'b1;
        repeat (3) begin
            step();
            check("arst_quiet", tick_c, 0);
        end
        step();
        check("arst_first_tick", tick_c, 1);

        // Randomized phase; bounds only move together with a load so the
        // loaded position is always inside them and the wrap span covers |vel|.
        for (int i = 0; i < 600; i++) begin
            load = ($urandom_range(0, 19) == 0);
            if (load) begin
                if ($urandom_range(0, 4) == 0) begin
                    pos_min  = 8'($urandom_range(128, 255));
                    pos_max  = 8'($urandom_range(0, 127));
                    load_pos = 8'($urandom);
                end else begin
                    pmin_r   = int'($urandom_range(0, 200));
                    pmax_r   = pmin_r + int'($urandom_range(8, 255 - pmin_r));
                    pos_min  = 8'(pmin_r);
                    pos_max  = 8'(pmax_r);
                    load_pos = 8'($urandom_range(pmin_r, pmax_r));
                end
                load_vel = 4'($urandom);
            end
            enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 15) == 0) period = 26'($urandom_range(0, 3));
            accel = 4'($urandom);
            vmax  = 3'($urandom);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
